// File: rtl/cpu6502_pkg.sv
// Shared constants and types for the 65C02 bus responder.
package cpu6502_pkg;

    localparam logic [15:0] VEC_NMI  = 16'hFFFA;
    localparam logic [15:0] VEC_RES  = 16'hFFFC;
    localparam logic [15:0] VEC_IRQ  = 16'hFFFE;
    localparam logic [7:0]  OPEN_BUS = 8'hFF;

    typedef enum logic [2:0] {
        IDLE    = 3'b001,
        WAIT    = 3'b010,
        RESPOND = 3'b100
    } resp_state_t;

    typedef enum logic [1:0] {
        TGT_NONE,
        TGT_RAM,
        TGT_VEC
    } tgt_t;

endpackage

// File: rtl/mem_responder_ram.sv
// Synchronous single-port byte RAM, one cycle read latency, read-before-write.
module mem_responder_ram #(
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic [AW-1:0] i_addr,
    input  logic          i_we,
    input  logic [7:0]    i_wdata,
    output logic [7:0]    o_rdata
);

    logic [7:0] r_mem [2**AW];

    // NOTE: the array has no reset so it maps onto block RAM; its contents survive RES.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        o_rdata <= r_mem[i_addr];
    end

endmodule

// File: rtl/mem_responder.sv
// Bus responder for the 65C02: decodes RAM window / vector table and paces
// every access with RDY after a programmable number of wait states.
module mem_responder
    import cpu6502_pkg::*;
#(
    parameter logic [15:0] RAM_BASE    = 16'h0000,
    parameter int          RAM_AW      = 12,
    parameter int          WAIT_STATES = 0,
    parameter logic [15:0] NMI_VEC     = 16'h0000,
    parameter logic [15:0] RESET_VEC   = 16'hE000,
    parameter logic [15:0] IRQ_VEC     = 16'h0000
) (
    input  logic        PHI_0,
    input  logic        RES,
    input  logic [15:0] AB,
    input  logic        RW,
    input  logic [7:0]  DB_OUT,
    output logic [7:0]  DB_IN,
    output logic        RDY
);

    localparam logic [3:0] WS_LAST = 4'(WAIT_STATES - 1);

    resp_state_t r_state, w_next;
    logic [3:0]  r_cnt;
    logic [15:0] r_addr;
    logic        r_rw;
    logic [7:0]  r_wdata;
    logic        r_rdy;
    logic [7:0]  r_db;
    logic        r_use_ram;

    logic [15:0] w_addr;
    logic        w_rw;
    logic [7:0]  w_wdata;
    tgt_t        w_tgt;
    logic [15:0] w_vec_word;
    logic [7:0]  w_const;
    logic        w_ram_we;
    logic [7:0]  w_ram_rdata;

    // In IDLE the live bus drives decode and RAM so a zero-wait access completes in two cycles.
    always_comb begin
        w_addr  = r_addr;
        w_rw    = r_rw;
        w_wdata = r_wdata;
        if (r_state == IDLE) begin
            w_addr  = AB;
            w_rw    = RW;
            w_wdata = DB_OUT;
        end
    end

    always_comb begin
        w_tgt = TGT_NONE;
        if (w_addr >= VEC_NMI) begin
            w_tgt = TGT_VEC;
        end else if ((w_addr >> RAM_AW) == (RAM_BASE >> RAM_AW)) begin
            w_tgt = TGT_RAM;
        end
    end

    always_comb begin
        w_vec_word = 16'hFFFF;
        case (w_addr[2:1])
            2'b01:   w_vec_word = NMI_VEC;
            2'b10:   w_vec_word = RESET_VEC;
            2'b11:   w_vec_word = IRQ_VEC;
            default: w_vec_word = 16'hFFFF;
        endcase
        w_const = (w_tgt == TGT_VEC) ? (w_addr[0] ? w_vec_word[15:8] : w_vec_word[7:0]) : OPEN_BUS;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = (WAIT_STATES == 0) ? RESPOND : WAIT;
            WAIT:    w_next = (r_cnt == 4'd0) ? RESPOND : WAIT;
            RESPOND: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign w_ram_we = (w_next == RESPOND) && !w_rw && (w_tgt == TGT_RAM);

    mem_responder_ram #(.AW(RAM_AW)) u_ram (
        .clk     (PHI_0),
        .i_addr  (w_addr[RAM_AW-1:0]),
        .i_we    (w_ram_we),
        .i_wdata (w_wdata),
        .o_rdata (w_ram_rdata)
    );

    // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge PHI_0 or negedge RES) begin
        if (!RES) begin
            r_state   <= IDLE;
            r_cnt     <= 4'd0;
            r_addr    <= 16'h0000;
            r_rw      <= 1'b1;
            r_wdata   <= 8'h00;
            r_rdy     <= 1'b1;
            r_db      <= OPEN_BUS;
            r_use_ram <= 1'b0;
        end else begin
            r_state <= w_next;
            r_rdy   <= (w_next != RESPOND);
            if (r_state == IDLE) begin
                r_addr  <= AB;
                r_rw    <= RW;
                r_wdata <= DB_OUT;
                r_cnt   <= WS_LAST;
            end else if (r_state == WAIT && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            // RAM reads are shown straight from the RAM output register, then frozen into r_db.
            if (w_next == RESPOND && w_rw) begin
                if (w_tgt == TGT_RAM) begin
                    r_use_ram <= 1'b1;
                end else begin
                    r_use_ram <= 1'b0;
                    r_db      <= w_const;
                end
            end else if (r_state == RESPOND && r_use_ram) begin
                r_db      <= w_ram_rdata;
                r_use_ram <= 1'b0;
            end
        end
    end

    assign DB_IN = r_use_ram ? w_ram_rdata : r_db;
    assign RDY   = r_rdy;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench: one responder with zero wait states, one with three.
module tb_mem_responder;

    typedef struct {
        logic [7:0] data;
        bit         chk;
        int         due;
    } exp_t;

    logic        clk = 1'b0;
    logic        res0_n = 1'b0, res3_n = 1'b0;
    logic [15:0] ab0 = 16'h0000, ab3 = 16'h0000;
    logic        rw0 = 1'b1, rw3 = 1'b1;
    logic [7:0]  dbo0 = 8'h00, dbo3 = 8'h00;
    logic [7:0]  dbi0, dbi3;
    logic        rdy0, rdy3;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t q0[$];
    exp_t q3[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    mem_responder #(.WAIT_STATES(0)) dut0 (
        .PHI_0(clk), .RES(res0_n), .AB(ab0), .RW(rw0),
        .DB_OUT(dbo0), .DB_IN(dbi0), .RDY(rdy0)
    );

    mem_responder #(.WAIT_STATES(3)) dut3 (
        .PHI_0(clk), .RES(res3_n), .AB(ab3), .RW(rw3),
        .DB_OUT(dbo3), .DB_IN(dbi3), .RDY(rdy3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic drive(input int d, input logic [15:0] a, input logic rw, input logic [7:0] wd);
        if (d == 0) begin
            ab0 = a; rw0 = rw; dbo0 = wd;
        end else begin
            ab3 = a; rw3 = rw; dbo3 = wd;
        end
    endtask

    // One complete access: present the bus, queue the expected response, hold for 2+WS edges.
    task automatic access(input int d, input logic [15:0] a, input logic rw, input logic [7:0] wd,
                          input logic [7:0] exp_data, input bit toggle);
        int   ws;
        exp_t e;
        ws = (d == 0) ? 0 : 3;
        drive(d, a, rw, wd);
        e.data = exp_data;
        e.chk  = rw;
        e.due  = cyc + 1 + ws;
        if (d == 0) q0.push_back(e); else q3.push_back(e);
        for (int i = 0; i < 1 + ws; i++) begin
            @(posedge clk); #1;
            if (toggle) drive(d, 16'($urandom), 1'($urandom_range(0, 1)), 8'($urandom));
        end
        @(posedge clk); #1;
    endtask

    task automatic rd(input int d, input logic [15:0] a, input logic [7:0] exp_data);
        access(d, a, 1'b1, 8'h00, exp_data, 1'b0);
    endtask

    task automatic wr(input int d, input logic [15:0] a, input logic [7:0] wd);
        access(d, a, 1'b0, wd, 8'h00, 1'b0);
    endtask

    always @(negedge clk) begin
        if (res0_n && rdy0 == 1'b0) begin
            if (q0.size() == 0) begin
                check("ws0_spurious_rdy", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q0.pop_front();
                check("ws0_rdy_cycle", cyc, e.due);
                if (e.chk) check("ws0_read_data", dbi0, e.data);
            end
        end
        if (res3_n && rdy3 == 1'b0) begin
            if (q3.size() == 0) begin
                check("ws3_spurious_rdy", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q3.pop_front();
                check("ws3_rdy_cycle", cyc, e.due);
                if (e.chk) check("ws3_read_data", dbi3, e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] a;
        logic [7:0]  wd;

        // Zero-wait responder
        repeat (3) @(posedge clk);
        #1;
        check("ws0_reset_rdy", rdy0, 1'b1);
        check("ws0_reset_db_in", dbi0, 8'hFF);
        res0_n = 1'b1;
        rd(0, 16'hFFFC, 8'h00);
        rd(0, 16'hFFFD, 8'hE0);
        rd(0, 16'hFFFA, 8'h00);
        wr(0, 16'h0200, 8'hA5);
        rd(0, 16'h0200, 8'hA5);
        wr(0, 16'h0FFF, 8'h3C);
        rd(0, 16'h0FFF, 8'h3C);
        rd(0, 16'h1000, 8'hFF);
        wr(0, 16'hFFFC, 8'h12);
        rd(0, 16'hFFFC, 8'h00);
        wr(0, 16'h0000, 8'h77);
        wr(0, 16'h8000, 8'h99);
        rd(0, 16'h0000, 8'h77);
        rd(0, 16'h8000, 8'hFF);
        access(0, 16'h0200, 1'b1, 8'h00, 8'hA5, 1'b1);
        for (int i = 0; i < 8; i++) begin
            a  = 16'(i * 16'h0201);
            wd = 8'(8'h5A ^ (i * 8'h13));
            wr(0, a, wd);
            rd(0, a, wd);
        end
        check("ws0_queue_drained", q0.size(), 0);
        res0_n = 1'b0;

        // Three-wait responder
        repeat (3) @(posedge clk);
        #1;
        check("ws3_reset_rdy", rdy3, 1'b1);
        check("ws3_reset_db_in", dbi3, 8'hFF);
        res3_n = 1'b1;
        rd(3, 16'hFFFC, 8'h00);
        rd(3, 16'hFFFD, 8'hE0);
        wr(3, 16'h0300, 8'h33);
        wr(3, 16'h0400, 8'hC3);
        access(3, 16'h0400, 1'b1, 8'h00, 8'hC3, 1'b1);
        rd(3, 16'h0300, 8'h33);

        // Abort a write two cycles into its wait states
        drive(3, 16'h0300, 1'b0, 8'h5A);
        @(posedge clk); #1;
        @(posedge clk); #1;
        res3_n = 1'b0;
        #1;
        check("ws3_midreset_rdy", rdy3, 1'b1);
        check("ws3_midreset_db_in", dbi3, 8'hFF);
        repeat (2) @(posedge clk);
        #1;
        res3_n = 1'b1;
        rd(3, 16'h0300, 8'h33);

        for (int i = 0; i < 8; i++) begin
            a  = 16'(i * 16'h0201);
            wd = 8'(8'hC0 + i * 7);
            wr(3, a, wd);
            rd(3, a, wd);
        end
        rd(3, 16'hFFFF, 8'h00);
        rd(3, 16'h1234, 8'hFF);
        check("ws3_queue_drained", q3.size(), 0);
        res3_n = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
